trg_ack_sequencer: RTL and testbench
====================================

Name: trg_ack_sequencer

Overview:
- Sequences the 12-channel TRG/ACK four-phase handshake to the daughter boards.
- The Wishbone slave supplies a channel mask, a timeout and a start pulse. The block raises TRG on each enabled channel, drops each TRG when its ACK arrives, then waits for the ACKs to release.
- Reports per-channel ACK/timeout status and pulses DONE_O.
- Sits between the Wishbone slave register file and the TRG/ACK pins.

Parameters:
- N_CH, 12, number of TRG/ACK channels.
- TIMEOUT_W, 16, width of timeout counter and TIMEOUT_I.

Ports:
- BOARD_CLOCK  in  1  single system clock; all logic rising-edge.
- RST_N  in  1  reset, synchronous, active-low.
- START_I  in  1  start request; sampled only in IDLE.
- ABORT_I  in  1  abort active sequence.
- CH_MASK_I  in  N_CH  channels to trigger; latched at start.
- TIMEOUT_I  in  TIMEOUT_W  phase timeout in cycles; 0 = wait forever; latched at start.
- ACK_I  in  N_CH  ACK bits from boards.
- TRG_O  out  N_CH  trigger bits to boards, registered.
- BUSY_O  out  1  high in any state except IDLE.
- DONE_O  out  1  one-cycle pulse at end of sequence.
- ACKED_O  out  N_CH  channels that acknowledged; held until next start.
- TMO_O  out  N_CH  channels that timed out or were aborted while pending; held until next start.
- ERR_O  out  1  stale ACK, release timeout or abort; held until next start.

Behaviour:
- Reset (RST_N low at an edge): state IDLE; TRG_O=0, BUSY_O=0, DONE_O=0, ACKED_O=0, TMO_O=0, ERR_O=0; timer=0. Reset in any state takes effect at that edge; TRG_O drops after that edge.
- ack_s: the internal ACK view, gated by the latched mask. Unmasked ACK bits are ignored everywhere.
- IDLE:
  - START_I=1 at edge k: latch mask/timeout; clear ACKED_O, TMO_O, ERR_O; enter CHECK; BUSY_O=1 after edge k.
  - If the latched mask is 0, go to DONE instead.
- CHECK (1 cycle):
  - If ack_s != 0: set ERR_O, TRG_O stays 0, go to DONE.
  - Otherwise TRG_O=mask and pending=mask after edge k+1; enter ASSERT; timer=0.
- ASSERT:
  - For each pending channel i with ack_s[i]=1 at edge m: after edge m, TRG_O[i]=0, pending[i]=0, ACKED_O[i]=1. Multiple channels in the same cycle are all handled.
  - timer increments each cycle while pending != 0.
  - If TIMEOUT_I != 0 and timer reaches TIMEOUT_I with pending != 0: at that edge TMO_O=pending, TRG_O=0, pending=0. Each TRG is high at most TIMEOUT_I cycles.
  - When pending == 0: enter RELEASE; timer=0.
  - An ACK arriving in the same cycle as the timeout counts as acked, not timed out.
- RELEASE:
  - Wait until (ack_s & ACKED_O) == 0, then go to DONE.
  - Timer runs with the same limit; on expiry set ERR_O and go to DONE.
- DONE: DONE_O=1 for exactly one cycle; next edge IDLE, BUSY_O=0.
- ABORT_I=1 in CHECK/ASSERT/RELEASE: next edge TRG_O=0, TMO_O|=pending, ERR_O=1, enter DONE. ABORT_I is ignored in IDLE and DONE.
- START_I while BUSY_O=1: ignored, no queueing.
- Timer saturates, never wraps; TIMEOUT_I=0 disables expiry in both phases.

Optional Feature:
- Macro TRG_ACK_SYNC_EN.
- Defined: ACK_I passes a 2-flop synchronizer before ack_s, adding +2 cycles from an ACK_I edge to its TRG_O/ACKED_O effect. Synchronizer flops reset to 0.
- Undefined: ack_s = ACK_I combinationally; ACK_I must already be synchronous to BOARD_CLOCK.

Test Plan:
- Mask 0x003, TIMEOUT 100, ACK[0] high 5 cycles after TRG rises, ACK[1] after 8, both drop 3 cycles later -> TRG[0] high 5 cycles, TRG[1] high 8 cycles; ACKED_O=0x003, TMO_O=0, ERR_O=0; single DONE_O pulse after both ACKs low.
- Mask 0x801, TIMEOUT 100, ACK[0] after 4 cycles, ACK[11] never -> TRG[11] high exactly 100 cycles; ACKED_O=0x001, TMO_O=0x800, ERR_O=0; DONE_O pulses.
- ACK[3]=1 before start, mask 0x008 -> TRG_O stays 0; ERR_O=1; DONE_O 2 cycles after START_I.
- Mask 0xFFF, ABORT_I at cycle 10 of ASSERT with ACKs on 0x00F -> TRG_O=0 next edge; ACKED_O=0x00F, TMO_O=0xFF0, ERR_O=1; DONE_O pulses.
- Mask 0 -> no TRG activity, DONE_O 1 cycle after START_I. Separately, RST_N low mid-ASSERT -> all outputs 0 after that edge; START_I while busy has no effect.
- With TRG_ACK_SYNC_EN defined, repeat the first scenario -> each TRG high 2 cycles longer (7 and 10 cycles), status identical.

Source files
------------

// File: rtl/trg_ack_sequencer.sv
// TRG/ACK four-phase handshake sequencer for the daughter-board channels.
// Define TRG_ACK_SYNC_EN to pass ACK_I through a 2-flop synchronizer.
module trg_ack_sequencer #(
   parameter int N_CH      = 12,
   parameter int TIMEOUT_W = 16
) (
   input  logic                 BOARD_CLOCK,
   input  logic                 RST_N,
   input  logic                 START_I,
   input  logic                 ABORT_I,
   input  logic [N_CH-1:0]      CH_MASK_I,
   input  logic [TIMEOUT_W-1:0] TIMEOUT_I,
   input  logic [N_CH-1:0]      ACK_I,
   output logic [N_CH-1:0]      TRG_O,
   output logic                 BUSY_O,
   output logic                 DONE_O,
   output logic [N_CH-1:0]      ACKED_O,
   output logic [N_CH-1:0]      TMO_O,
   output logic                 ERR_O
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ASSERT,
      S_RELEASE,
      S_DONE
   } state_t;

   localparam logic [TIMEOUT_W-1:0] T_ONE = TIMEOUT_W'(1);

   state_t               state_q;
   logic [N_CH-1:0]      mask_q;
   logic [TIMEOUT_W-1:0] tmo_q;
   logic [N_CH-1:0]      pend_q;
   logic [TIMEOUT_W-1:0] timer_q;

   logic [N_CH-1:0]      ack_s;
   logic [N_CH-1:0]      ack_hit;
   logic [N_CH-1:0]      pend_rem;
   logic [TIMEOUT_W-1:0] timer_inc;
   logic                 expire;

`ifdef TRG_ACK_SYNC_EN
   logic [N_CH-1:0] ack_m;
   logic [N_CH-1:0] ack_r;

   always_ff @(posedge BOARD_CLOCK) begin
      if (!RST_N) begin
         ack_m <= '0;
         ack_r <= '0;
      end else begin
         ack_m <= ACK_I;
         ack_r <= ack_m;
      end
   end

   assign ack_s = ack_r & mask_q;
`else
   assign ack_s = ACK_I & mask_q;
`endif

   assign ack_hit   = pend_q & ack_s;
   assign pend_rem  = pend_q & ~ack_hit;
   // Saturating count; a zero limit never expires.
   assign timer_inc = (timer_q == '1) ? timer_q : timer_q + T_ONE;
   assign expire    = (tmo_q != '0) && (timer_inc >= tmo_q);

   always_ff @(posedge BOARD_CLOCK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         tmo_q   <= '0;
         pend_q  <= '0;
         timer_q <= '0;
         TRG_O   <= '0;
         BUSY_O  <= 1'b0;
         DONE_O  <= 1'b0;
         ACKED_O <= '0;
         TMO_O   <= '0;
         ERR_O   <= 1'b0;
      end else begin
         DONE_O <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (START_I) begin
                  mask_q  <= CH_MASK_I;
                  tmo_q   <= TIMEOUT_I;
                  timer_q <= '0;
                  ACKED_O <= '0;
                  TMO_O   <= '0;
                  ERR_O   <= 1'b0;
                  BUSY_O  <= 1'b1;
                  if (CH_MASK_I == '0) begin
                     DONE_O  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               // An ACK already high before TRG rises is stale.
               if (ABORT_I || (ack_s != '0)) begin
                  ERR_O   <= 1'b1;
                  DONE_O  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  TRG_O   <= mask_q;
                  pend_q  <= mask_q;
                  timer_q <= '0;
                  state_q <= S_ASSERT;
               end
            end
            S_ASSERT: begin
               if (ABORT_I) begin
                  TRG_O   <= '0;
                  pend_q  <= '0;
                  TMO_O   <= TMO_O | pend_q;
                  ERR_O   <= 1'b1;
                  DONE_O  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  ACKED_O <= ACKED_O | ack_hit;
                  timer_q <= timer_inc;
                  if (expire) begin
                     TMO_O  <= TMO_O | pend_rem;
                     TRG_O  <= '0;
                     pend_q <= '0;
                  end else begin
                     TRG_O  <= pend_rem;
                     pend_q <= pend_rem;
                  end
                  if (expire || (pend_rem == '0)) begin
                     timer_q <= '0;
                     state_q <= S_RELEASE;
                  end
               end
            end
            S_RELEASE: begin
               if (ABORT_I) begin
                  ERR_O   <= 1'b1;
                  DONE_O  <= 1'b1;
                  state_q <= S_DONE;
               end else if ((ack_s & ACKED_O) == '0) begin
                  DONE_O  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  timer_q <= timer_inc;
                  if (expire) begin
                     ERR_O   <= 1'b1;
                     DONE_O  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               BUSY_O  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trg_ack_sequencer.sv
// Bench for trg_ack_sequencer: directed table, hand sequences, random runs.
// Define TRG_ACK_SYNC_EN here as for the RTL to check the synchronized build.
module tb_trg_ack_sequencer;

   localparam int N       = 12;
`ifdef TRG_ACK_SYNC_EN
   localparam int L       = 2;
`else
   localparam int L       = 0;
`endif
   localparam int NEVER   = 1 << 27;
   localparam int FOREVER = 1 << 26;
   localparam int INF     = 1 << 28;
   localparam int NT      = 9;
   localparam int NR      = 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [N-1:0]  mask_in = '0;
   logic [15:0]   tmo_in = '0;
   logic [N-1:0]  ack = '0;
   logic [N-1:0]  trg;
   logic          busy;
   logic          done;
   logic [N-1:0]  acked;
   logic [N-1:0]  tmo_o;
   logic          err;

   trg_ack_sequencer #(.N_CH(N), .TIMEOUT_W(16)) dut (
      .BOARD_CLOCK(clk),
      .RST_N(rst_n),
      .START_I(start),
      .ABORT_I(abort),
      .CH_MASK_I(mask_in),
      .TIMEOUT_I(tmo_in),
      .ACK_I(ack),
      .TRG_O(trg),
      .BUSY_O(busy),
      .DONE_O(done),
      .ACKED_O(acked),
      .TMO_O(tmo_o),
      .ERR_O(err)
   );

   always #5 clk = ~clk;

   // at: first edge (relative to the START edge 0) with ACK_I high,
   // len: number of edges it stays high; ab: abort edge, 0 = none.
   typedef struct {
      logic [N-1:0] mask;
      logic [15:0]  tmo;
      int           at[N];
      int           len[N];
      int           ab;
      logic [N-1:0] e_acked;
      logic [N-1:0] e_tmo;
      logic         e_err;
      int           e_done;
      int           e_trg[N];
   } scn_t;

   scn_t tbl[NT];
   scn_t cur;
   int   n_vec = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic new_scn(input int k, input logic [N-1:0] m,
                          input logic [15:0] t, input int ab,
                          input logic [N-1:0] ea, input logic [N-1:0] et,
                          input logic ee, input int ed);
      tbl[k].mask = m;
      tbl[k].tmo = t;
      tbl[k].ab = ab;
      tbl[k].e_acked = ea;
      tbl[k].e_tmo = et;
      tbl[k].e_err = ee;
      tbl[k].e_done = ed;
      for (int i = 0; i < N; i++) begin
         tbl[k].at[i] = NEVER;
         tbl[k].len[i] = 0;
         tbl[k].e_trg[i] = 0;
      end
   endtask

   task automatic set_ch(input int k, input int ch, input int at,
                         input int len, input int etrg);
      tbl[k].at[ch] = at;
      tbl[k].len[ch] = len;
      tbl[k].e_trg[ch] = etrg;
   endtask

   // Closed-form outcome of one sequence from the handshake rules.
   task automatic model();
      int lo;
      int hi[N];
      int t[N];
      int x, a, b, r, xr, maxt;
      bit stale;
      b = (cur.ab == 0) ? INF : cur.ab;
      x = (cur.tmo == 0) ? INF : 1 + int'(cur.tmo);
      cur.e_acked = '0;
      cur.e_tmo = '0;
      cur.e_err = 1'b0;
      for (int i = 0; i < N; i++) cur.e_trg[i] = 0;
      if (cur.mask == '0) begin
         cur.e_done = 0;
         return;
      end
      stale = 1'b0;
      maxt = 0;
      for (int i = 0; i < N; i++) begin
         hi[i] = -INF;
         t[i] = INF;
         if (cur.mask[i] && cur.at[i] != NEVER) begin
            lo = cur.at[i] + L;
            hi[i] = (cur.len[i] == FOREVER) ? INF : lo + cur.len[i] - 1;
            if (lo <= 1 && hi[i] >= 1) stale = 1'b1;
            if (hi[i] >= 2) t[i] = (lo > 2) ? lo : 2;
         end
         if (cur.mask[i] && t[i] > maxt) maxt = t[i];
      end
      if (stale) begin
         cur.e_err = 1'b1;
         cur.e_done = 1;
         return;
      end
      a = (x < maxt) ? x : maxt;
      if (b <= a) begin
         for (int i = 0; i < N; i++) begin
            if (!cur.mask[i]) continue;
            if (t[i] < b) begin
               cur.e_acked[i] = 1'b1;
               cur.e_trg[i] = t[i] - 1;
            end else begin
               cur.e_tmo[i] = 1'b1;
               cur.e_trg[i] = b - 1;
            end
         end
         cur.e_err = 1'b1;
         cur.e_done = b;
         return;
      end
      r = a + 1;
      for (int i = 0; i < N; i++) begin
         if (!cur.mask[i]) continue;
         if (t[i] <= x) begin
            cur.e_acked[i] = 1'b1;
            cur.e_trg[i] = t[i] - 1;
            if (hi[i] + 1 > r) r = hi[i] + 1;
         end else begin
            cur.e_tmo[i] = 1'b1;
            cur.e_trg[i] = x - 1;
         end
      end
      xr = (cur.tmo == 0) ? INF : a + int'(cur.tmo);
      if (b <= r && b <= xr) begin
         cur.e_err = 1'b1;
         cur.e_done = b;
      end else if (r <= xr) begin
         cur.e_done = r;
      end else begin
         cur.e_err = 1'b1;
         cur.e_done = xr;
      end
   endtask

   task automatic gen_random();
      int r;
      cur.mask = N'($urandom());
      if ($urandom_range(0, 15) == 0) cur.mask = '0;
      cur.tmo = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
      cur.ab = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 80) : 0;
      for (int i = 0; i < N; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) cur.at[i] = NEVER;
         else if (r == 1) cur.at[i] = -2;
         else cur.at[i] = $urandom_range(2, 50);
         cur.len[i] = ($urandom_range(0, 4) == 0) ? FOREVER : $urandom_range(1, 30);
      end
      model();
      if (cur.e_done > 500) begin
         cur.ab = $urandom_range(2, 80);
         model();
      end
   endtask

   task automatic run_scn(input string tag);
      int cnt[N];
      int done_n, done_at, limit, busy_bad;
      limit = cur.e_done + 3;
      done_n = 0;
      done_at = -1;
      busy_bad = 0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int rel = -4; rel <= limit; rel++) begin
         start = (rel == 0) ||
                 (rel >= 1 && rel <= cur.e_done && $urandom_range(0, 7) == 0);
         abort = (cur.ab != 0 && rel == cur.ab) ||
                 ((rel < 0 || rel == cur.e_done + 1) && $urandom_range(0, 3) == 0);
         mask_in = (rel == 0) ? cur.mask : N'($urandom());
         tmo_in = (rel == 0) ? cur.tmo : 16'($urandom());
         for (int i = 0; i < N; i++) begin
            if (cur.mask[i])
               ack[i] = (cur.at[i] != NEVER) && (rel >= cur.at[i]) &&
                        (rel <= cur.at[i] + cur.len[i] - 1);
            else
               ack[i] = 1'($urandom());
         end
         @(posedge clk);
         #1;
         if (rel >= 0)
            for (int i = 0; i < N; i++) if (trg[i] === 1'b1) cnt[i]++;
         if (done === 1'b1) begin
            done_n++;
            done_at = rel;
         end
         if (busy !== (rel >= 0 && rel <= cur.e_done)) busy_bad++;
      end
      start = 1'b0;
      abort = 1'b0;
      ack = '0;
      check($sformatf("%s done_edge", tag), 64'(done_at), 64'(cur.e_done));
      check($sformatf("%s done_pulses", tag), 64'(done_n), 64'd1);
      check($sformatf("%s acked", tag), 64'(acked), 64'(cur.e_acked));
      check($sformatf("%s tmo", tag), 64'(tmo_o), 64'(cur.e_tmo));
      check($sformatf("%s err", tag), 64'(err), 64'(cur.e_err));
      check($sformatf("%s busy_bad_cycles", tag), 64'(busy_bad), 64'd0);
      for (int i = 0; i < N; i++)
         check($sformatf("%s trg%0d_cycles", tag, i), 64'(cnt[i]),
               64'(cur.e_trg[i]));
   endtask

   task automatic check_zero(input string tag);
      check($sformatf("%s trg", tag), 64'(trg), 64'd0);
      check($sformatf("%s busy", tag), 64'(busy), 64'd0);
      check($sformatf("%s done", tag), 64'(done), 64'd0);
      check($sformatf("%s acked", tag), 64'(acked), 64'd0);
      check($sformatf("%s tmo", tag), 64'(tmo_o), 64'd0);
      check($sformatf("%s err", tag), 64'(err), 64'd0);
   endtask

   initial begin
      new_scn(0, 12'h003, 16'd100, 0, 12'h003, 12'h000, 1'b0, 12 + L);
      set_ch(0, 0, 6, 6, 5 + L);
      set_ch(0, 1, 9, 3, 8 + L);
      new_scn(1, 12'h801, 16'd100, 0, 12'h001, 12'h800, 1'b0, 102);
      set_ch(1, 0, 5, 3, 4 + L);
      set_ch(1, 11, NEVER, 0, 100);
      new_scn(2, 12'h008, 16'd100, 0, 12'h000, 12'h000, 1'b1, 1);
      set_ch(2, 3, -3, 10, 0);
      new_scn(3, 12'hFFF, 16'd100, 11, 12'h00F, 12'hFF0, 1'b1, 11);
      for (int i = 0; i < 4; i++) set_ch(3, i, 3 + i, FOREVER, 2 + i + L);
      for (int i = 4; i < N; i++) set_ch(3, i, NEVER, 0, 10);
      new_scn(4, 12'h000, 16'd100, 0, 12'h000, 12'h000, 1'b0, 0);
      new_scn(5, 12'h0F0, 16'd0, 0, 12'h0F0, 12'h000, 1'b0, 220 + L);
      set_ch(5, 4, 150, 5, 149 + L);
      set_ch(5, 5, 20, 200, 19 + L);
      set_ch(5, 6, 30, 10, 29 + L);
      set_ch(5, 7, 2, 1, 1 + L);
      new_scn(6, 12'h002, 16'd10, 0, 12'h002, 12'h000, 1'b1, 14 + L);
      set_ch(6, 1, 4, FOREVER, 3 + L);
      new_scn(7, 12'h00C, 16'd6, 0, 12'h004, 12'h008, 1'b0, 9);
      set_ch(7, 2, 7 - L, 2, 6);
      set_ch(7, 3, NEVER, 0, 6);
      new_scn(8, 12'h001, 16'd0, 10, 12'h001, 12'h000, 1'b1, 10);
      set_ch(8, 0, 3, FOREVER, 2 + L);

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;

      // Reset while channels are asserted and one is already acked.
      mask_in = '1;
      tmo_in = 16'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      ack = 12'h001;
      repeat (4) @(posedge clk);
      #1;
      check("midrst pre trg", 64'(trg), 64'hFFE);
      check("midrst pre acked", 64'(acked), 64'h001);
      check("midrst pre busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_zero("midrst");
      rst_n = 1'b1;
      ack = '0;
      repeat (3) @(posedge clk);
      #1;

      for (int k = 0; k < NT; k++) begin
         cur = tbl[k];
         run_scn($sformatf("dir%0d", k));
      end

      for (int k = 0; k < NR; k++) begin
         gen_random();
         run_scn($sformatf("rnd%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
